instruction_loader: RTL
=======================

// Module: instruction_loader
// PURPOSE
//  Debug-unit side writer that fills instruction memory with the program the fetch/decode stages consume.
//  Assembles 8-bit UART receive bytes into 32-bit words and writes them to consecutive word addresses.
//  Terminates on the HALT word 32'hFFFFFFFF, which is itself written so decode sees it and halts.
//  Sits between uart_rx and the instruction-memory write port; the pipeline is held in halt while o_busy=1.
// PARAMETERS
//  NB_ADDR         10     byte-address width of instruction memory (word aligned, [1:0]=2'b00)
//  MEM_WORDS       256    capacity in words; must be <= 2**(NB_ADDR-2)
//  TIMEOUT_CYCLES  100000 max idle cycles between bytes of a partially received word
// PORTS
//  i_clk          in   1        clock
//  i_reset        in   1        asynchronous reset, active-low
//  i_start        in   1        load command pulse from debug unit
//  i_rx_data      in   8        received byte
//  i_rx_valid     in   1        1-cycle strobe: i_rx_data valid
//  o_imem_we      out  1        instruction-memory write enable (1-cycle pulse)
//  o_imem_addr    out  NB_ADDR  byte address of the word being written
//  o_imem_data    out  32       word being written
//  o_busy         out  1        1 while in LOAD (pipeline must stay halted)
//  o_done         out  1        level: last load ended with HALT written
//  o_error        out  1        level: last load aborted (overflow or timeout)
//  o_word_count   out  NB_ADDR-1  words written in current/last load (HALT included)
// BEHAVIOUR
//  Reset (i_reset=0, async): state IDLE; all outputs 0; byte counter, word counter, timeout counter 0.
//  States: IDLE, LOAD, DONE, ERROR.
//   IDLE/DONE/ERROR --i_start--> LOAD: clear o_done, o_error, counters, o_word_count; o_busy=1 next cycle.
//   i_start while in LOAD is ignored. i_rx_valid outside LOAD is ignored (byte dropped).
//  Byte order: big-endian; 1st byte of a word -> [31:24], 4th -> [7:0].
//  In LOAD, each accepted byte shifts into a 32-bit assembler, byte counter increments mod 4.
//  4th byte accepted in cycle N -> cycle N+1: o_imem_we=1, o_imem_data=word, o_imem_addr=word_count<<2;
//   word_count increments at the same edge the pulse ends. Bytes arriving in cycle N+1 are accepted
//   into the next word (no drop, back-to-back strobes supported).
//  o_imem_addr/o_imem_data hold their last value when o_imem_we=0.
//  HALT: if the written word == 32'hFFFFFFFF -> after its write pulse, state DONE, o_done=1, o_busy=0.
//  Overflow: if a non-HALT word is written at index MEM_WORDS-1 -> ERROR (the write itself occurs);
//   no write ever targets index >= MEM_WORDS.
//  Timeout: counter runs only while byte counter != 0; reset on every accepted byte; reaching
//   TIMEOUT_CYCLES -> ERROR, partial word discarded, no write.
//  Simultaneous timeout expiry and byte strobe: byte wins (counter reset, no error).
//  o_error/o_done are mutually exclusive; both 0 in IDLE and LOAD.
//  Reset mid-LOAD: abort immediately, any pending write pulse suppressed, memory contents left as is.
// STRUCTURE
//  Shared package loader_pkg: HALT_WORD = 32'hFFFFFFFF, state localparams (IDLE/LOAD/DONE/ERROR, 2 bits).
//  Sub-module word_assembler: byte shift register + mod-4 counter, o_word_valid pulse; cleared on start.
//  Top: FSM, word/address counter, timeout counter, registered write port.
// TESTING
//  Start, bytes 20 08 00 05 / FF FF FF FF -> we at addr 0 data 32'h20080005, addr 4 data FFFFFFFF; done=1, count=2.
//  Back-to-back strobes every cycle for 3 words + HALT -> 4 writes, addrs 0,4,8,12, no byte lost.
//  MEM_WORDS=4, send 4 non-HALT words -> 4 writes (last at addr 12), error=1, 5th word produces no write.
//  2 bytes then silence TIMEOUT_CYCLES -> error=1, no write; byte on expiry cycle -> no error.
//  Reset low mid-word and mid-pulse -> all outputs 0 same cycle; i_start after release restarts at addr 0.
//  i_rx_valid in IDLE and i_start during LOAD -> ignored, no write, count unchanged.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared constants for the instruction loader: HALT marker and FSM state encoding.
// No logic; no latency; no flow control.
// Imported by the loader top and its word assembler.
package loader_pkg;

    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DONE  = 2'd2,
        ST_ERROR = 2'd3
    } state_t;

endpackage

// File: rtl/word_assembler.sv
// Big-endian byte-to-word assembler: four accepted bytes form one 32-bit word.
// Word valid is combinational in the cycle the 4th byte is accepted.
// No backpressure: every strobed byte is taken; i_clear drops any partial word.
module word_assembler (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_clear,
    input  logic        i_byte_vld,
    input  logic [7:0]  i_byte_dat,
    output logic        o_word_vld,
    output logic [31:0] o_word_dat,
    output logic [1:0]  o_byte_cnt
);

    logic [23:0] shift_q;

    assign o_word_vld = i_byte_vld && (o_byte_cnt == 2'd3);
    assign o_word_dat = {shift_q, i_byte_dat};

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            shift_q    <= '0;
            o_byte_cnt <= '0;
        end else if (i_clear) begin
            shift_q    <= '0;
            o_byte_cnt <= '0;
        end else if (i_byte_vld) begin
            shift_q    <= {shift_q[15:0], i_byte_dat};
            o_byte_cnt <= o_byte_cnt + 2'd1;
        end
    end

endmodule

// File: rtl/instruction_loader.sv
// Writes UART-received program words into instruction memory until HALT, overflow or timeout.
// Write pulse appears one cycle after the 4th byte of a word is strobed.
// No backpressure: bytes are accepted every cycle while loading, dropped otherwise.
module instruction_loader
    import loader_pkg::*;
#(
    parameter int NB_ADDR        = 10,
    parameter int MEM_WORDS      = 256,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic [7:0]         i_rx_data,
    input  logic               i_rx_valid,
    output logic               o_imem_we,
    output logic [NB_ADDR-1:0] o_imem_addr,
    output logic [31:0]        o_imem_data,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_error,
    output logic [NB_ADDR-2:0] o_word_count
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [NB_ADDR-2:0] LAST_IDX = (NB_ADDR-1)'(MEM_WORDS - 1);
    localparam logic [NB_ADDR-2:0] WC_ONE   = (NB_ADDR-1)'(1);
    localparam logic [TW-1:0]      TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0]      TMO_ONE  = TW'(1);

    state_t        state;
    logic [TW-1:0] tmo_cnt;
    logic          asm_clear;
    logic          asm_byte_vld;
    logic          asm_word_vld;
    logic [31:0]   asm_word_dat;
    logic [1:0]    asm_byte_cnt;

    assign asm_clear    = i_start && (state != ST_LOAD);
    assign asm_byte_vld = i_rx_valid && (state == ST_LOAD);

    word_assembler u_word_assembler (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_clear    (asm_clear),
        .i_byte_vld (asm_byte_vld),
        .i_byte_dat (i_rx_data),
        .o_word_vld (asm_word_vld),
        .o_word_dat (asm_word_dat),
        .o_byte_cnt (asm_byte_cnt)
    );

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state        <= ST_IDLE;
            tmo_cnt      <= '0;
            o_imem_we    <= 1'b0;
            o_imem_addr  <= '0;
            o_imem_data  <= '0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_error      <= 1'b0;
            o_word_count <= '0;
        end else begin
            o_imem_we <= 1'b0;
            case (state)
                ST_LOAD: begin
                    // Decide termination on the word currently being written, as its pulse ends.
                    if (o_imem_we) begin
                        o_word_count <= o_word_count + WC_ONE;
                        if (o_imem_data == HALT_WORD) begin
                            state  <= ST_DONE;
                            o_busy <= 1'b0;
                            o_done <= 1'b1;
                        end else if (o_word_count == LAST_IDX) begin
                            state   <= ST_ERROR;
                            o_busy  <= 1'b0;
                            o_error <= 1'b1;
                        end
                    end
                    if (asm_word_vld) begin
                        o_imem_we   <= 1'b1;
                        o_imem_addr <= NB_ADDR'({o_word_count, 2'b00});
                        o_imem_data <= asm_word_dat;
                    end
                    // A byte arriving on the expiry cycle takes priority over the timeout.
                    if (i_rx_valid) begin
                        tmo_cnt <= '0;
                    end else if (asm_byte_cnt != 2'd0) begin
                        if (tmo_cnt == TMO_LAST) begin
                            state   <= ST_ERROR;
                            o_busy  <= 1'b0;
                            o_error <= 1'b1;
                        end else begin
                            tmo_cnt <= tmo_cnt + TMO_ONE;
                        end
                    end
                end
                default: begin
                    if (i_start) begin
                        state        <= ST_LOAD;
                        tmo_cnt      <= '0;
                        o_busy       <= 1'b1;
                        o_done       <= 1'b0;
                        o_error      <= 1'b0;
                        o_word_count <= '0;
                    end
                end
            endcase
        end
    end

endmodule
